// File: rtl/trace_stack.sv
// Assignment-trail stack for the DPLL core: records decided/forced assignments,
// supports single push/pop and a multi-cycle backtrack that flips the latest decision.
module trace_stack #(
    parameter int DEPTH = 128,
    parameter int VAR_W = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_en,
    input  logic             push_type,
    input  logic             push_val,
    input  logic [VAR_W-1:0] push_var,
    input  logic             pop_en,
    input  logic             bt_start,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] level,
    output logic             top_type,
    output logic             top_val,
    output logic [VAR_W-1:0] top_var,
    output logic             unassign_valid,
    output logic [VAR_W-1:0] unassign_var,
    output logic             bt_done,
    output logic [VAR_W-1:0] bt_flip_var,
    output logic             bt_flip_val,
    output logic             bt_unsat,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W  = VAR_W + 2;

    typedef enum logic {IDLE, BT_POP} state_t;

    state_t             state;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]  top_idx;
    logic [ENT_W-1:0]   top_entry;
    logic [CNT_W-1:0]   n_count, n_level;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_idx;
    logic [ENT_W-1:0]   wr_data;
    logic               n_uv, n_done, n_unsat, n_ovf, n_unf, n_fval;
    logic [VAR_W-1:0]   n_uvar, n_fvar;
    logic               go_bt, bt_finish;
    logic [ADDR_W-1:0]  n_top_idx;
    logic [ENT_W-1:0]   n_top;

    // Next-state datapath; the top entry is looked ahead so top_* stays registered.
    always_comb begin
        top_idx   = ADDR_W'(count - CNT_W'(1));
        top_entry = mem[top_idx];
        n_count   = count;
        n_level   = level;
        wr_en     = 1'b0;
        wr_idx    = ADDR_W'(count);
        wr_data   = {push_type, push_val, push_var};
        n_uv      = 1'b0;
        n_uvar    = unassign_var;
        n_done    = 1'b0;
        n_fvar    = bt_flip_var;
        n_fval    = bt_flip_val;
        n_unsat   = 1'b0;
        n_ovf     = 1'b0;
        n_unf     = 1'b0;
        go_bt     = 1'b0;
        bt_finish = 1'b0;
        case (state)
            IDLE: begin
                if (bt_start) begin
                    if (level == '0) n_unsat = 1'b1;
                    else             go_bt   = 1'b1;
                end else if (pop_en) begin
                    if (count == '0) begin
                        n_unf = 1'b1;
                    end else begin
                        n_count = count - CNT_W'(1);
                        if (!top_entry[ENT_W-1]) n_level = level - CNT_W'(1);
                        n_uv   = 1'b1;
                        n_uvar = top_entry[VAR_W-1:0];
                    end
                end else if (push_en) begin
                    if (count == CNT_W'(DEPTH)) begin
                        n_ovf = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        n_count = count + CNT_W'(1);
                        if (!push_type) n_level = level + CNT_W'(1);
                    end
                end
            end
            BT_POP: begin
                if (top_entry[ENT_W-1]) begin
                    n_count = count - CNT_W'(1);
                    n_uv    = 1'b1;
                    n_uvar  = top_entry[VAR_W-1:0];
                end else begin
                    wr_en     = 1'b1;
                    wr_idx    = top_idx;
                    wr_data   = {1'b1, ~top_entry[VAR_W], top_entry[VAR_W-1:0]};
                    n_level   = level - CNT_W'(1);
                    n_done    = 1'b1;
                    n_fvar    = top_entry[VAR_W-1:0];
                    n_fval    = ~top_entry[VAR_W];
                    bt_finish = 1'b1;
                end
            end
            default: ;
        endcase
        n_top_idx = ADDR_W'(n_count - CNT_W'(1));
        if (n_count == '0)                     n_top = '0;
        else if (wr_en && wr_idx == n_top_idx) n_top = wr_data;
        else                                   n_top = mem[n_top_idx];
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // Control FSM and all registered outputs; reset aborts a backtrack at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            count          <= '0;
            level          <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            {top_type, top_val, top_var} <= '0;
            unassign_valid <= 1'b0;
            unassign_var   <= '0;
            bt_done        <= 1'b0;
            bt_flip_var    <= '0;
            bt_flip_val    <= 1'b0;
            bt_unsat       <= 1'b0;
            overflow_err   <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (go_bt)     begin state <= BT_POP; busy <= 1'b1; end
                BT_POP:  if (bt_finish) begin state <= IDLE;   busy <= 1'b0; end
                default: begin state <= IDLE; busy <= 1'b0; end
            endcase
            count          <= n_count;
            level          <= n_level;
            full           <= (n_count == CNT_W'(DEPTH));
            empty          <= (n_count == '0);
            {top_type, top_val, top_var} <= n_top;
            unassign_valid <= n_uv;
            unassign_var   <= n_uvar;
            bt_done        <= n_done;
            bt_flip_var    <= n_fvar;
            bt_flip_val    <= n_fval;
            bt_unsat       <= n_unsat;
            overflow_err   <= n_ovf;
            underflow_err  <= n_unf;
        end
    end

endmodule

// File: doc/trace_stack.md
Name: trace_stack

Overview:
- Clocked, parametrised assignment-trail stack for the DPLL solver core.
- Records every decided and forced variable assignment in order.
- Supports single push/pop and a hardware multi-cycle backtrack: it unwinds forced entries down to the most recent decision, then flips that decision in place.
- Sits between the decision/BCP units and the variable-assignment memory. It drives unassign events to that memory.

Parameters:
- DEPTH, 128, maximum stored entries (≥2).
- VAR_W, 9, variable index width.
- CNT_W, $clog2(DEPTH+1), width of count/level.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- push_en  in  1  push request
- push_type  in  1  0=decide, 1=forced
- push_val  in  1  assigned value (1=T, 0=F)
- push_var  in  VAR_W  variable index
- pop_en  in  1  single pop request
- bt_start  in  1  start backtrack
- busy  out  1  backtrack in progress
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  CNT_W  entries stored
- level  out  CNT_W  decision entries stored
- top_type, top_val  out  1 each  top entry fields (0 when empty)
- top_var  out  VAR_W  top entry index (0 when empty)
- unassign_valid  out  1  one-cycle pulse: entry removed
- unassign_var  out  VAR_W  index of removed entry
- bt_done  out  1  one-cycle pulse: decision flipped
- bt_flip_var  out  VAR_W  flipped variable
- bt_flip_val  out  1  new value of flipped variable
- bt_unsat  out  1  one-cycle pulse: backtrack with level==0
- overflow_err  out  1  one-cycle pulse: push while full
- underflow_err  out  1  one-cycle pulse: pop while empty

Behaviour:
- Reset: synchronous, active-high.
  - state=IDLE; count=0, level=0.
  - All pulse outputs 0, busy=0, empty=1, full=0, top_*=0, bt_flip_*=0, unassign_var=0.
  - Entry storage need not be cleared.
  - Reset mid-backtrack aborts immediately, with the same reset values.
- Entry format: {type, val, var}. Entry slot i is valid for i<count.
- All outputs are registered. top_* reflects entry[count-1] after each edge.
- FSM states: IDLE, BT_POP.
- IDLE command priority: bt_start > pop_en > push_en. Lower-priority requests in the same cycle are ignored, with no error.
- Commands are accepted only in IDLE. In BT_POP, push_en, pop_en and bt_start are ignored.
- Push (IDLE):
  - If not full: write entry[count], count+1, level+1 if push_type==0.
  - If full: no state change; overflow_err pulses the next cycle.
- Pop (IDLE):
  - If not empty: count-1, level-1 if the top entry is a decision; unassign_valid=1 and unassign_var=top var the next cycle.
  - If empty: underflow_err pulses; no change.
- Backtrack start (IDLE):
  - If level==0: bt_unsat pulses the next cycle; stack unchanged; stay IDLE.
  - Otherwise: busy=1, go to BT_POP.
- BT_POP, one entry per cycle:
  - Top forced: pop it, count-1, unassign_valid pulse with its var.
  - Top decision: rewrite in place as type=1, val=~val; level-1; count unchanged.
  - After the flip: bt_done=1, bt_flip_var=var, bt_flip_val=~val, busy=0, return to IDLE.
- Backtrack latency: with k forced entries above the top decision, unassign pulses occur on k consecutive cycles starting 1 cycle after the bt_start edge. bt_done occurs k+1 cycles after the bt_start edge. busy is high for k+1 cycles.
- bt_done is never asserted in the same cycle as unassign_valid.
- Arithmetic bounds: count never wraps (0..DEPTH); level ≤ count always.
- A stack full of forced entries plus one decision at slot 0 must backtrack correctly; k = DEPTH-1 is the worst case.
- Push of a forced entry when level==0 is legal. These are level-0 implications, which remain permanent.

Test Plan:
1. Reset, then push (D,T,5),(F,F,7),(F,T,9) -> count=3, level=1, top=(1,1,9), empty=0.
2. Then bt_start -> unassign 9 at +1, unassign 7 at +2, bt_done at +3 with flip_var=5, flip_val=0; busy high 3 cycles; count=1, level=0, top=(1,0,5).
3. Then bt_start again -> bt_unsat pulse at +1; count=1 unchanged; busy never high.
4. Fill to DEPTH=128 with forced entries over one decision at slot 0, then push -> overflow_err pulse, count=128, full=1; then bt_start -> 127 unassign pulses, bt_done at +128.
5. Empty stack, pop_en -> underflow_err pulse, count=0. Push and pop_en together with 1 entry stored -> pop wins: count=0, unassign pulse.
6. Assert reset on the 2nd cycle of a backtrack with 4 forced entries above the decision -> next cycle busy=0, count=0, level=0, no bt_done. push_en during BT_POP is ignored (count unchanged by push).
